mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 50 +++++
 rtl/mem_ctrl_if.sv | 34 +++
 rtl/mem_ctrl_ext.sv | 34 +++
 rtl/mem_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: state, request, width and owner codes.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MEM_RD = 2'd1,
    ST_MEM_WR = 2'd2,
    ST_REPLAY = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'b00,
    REQ_LOAD  = 2'b01,
    REQ_STORE = 2'b10
  } mem_req_e;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'b00,
    WIDTH_HALF = 2'b01,
    WIDTH_WORD = 2'b10
  } mem_width_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_MEM  = 2'b10
  } owner_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        width;
    logic              sgn;
  } mem_txn_t;

  // Index of the last byte of an access (N-1); widths 10 and 11 are both words.
  function automatic logic [CNT_W-1:0] last_byte_idx(input logic [1:0] width);
    case (width)
      WIDTH_BYTE: return CNT_W'(0);
      WIDTH_HALF: return CNT_W'(1);
      default:    return CNT_W'(3);
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// IF / MEM / byte-RAM signal bundle; master is the surrounding system, slave is mem_ctrl.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic              if_request;
  logic [ADDR_W-1:0] if_addr;
  logic [BYTE_W-1:0] mem_ctrl_data;
  logic [1:0]        if_or_mem_o;

  logic [1:0]        mem_request;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        mem_width;
  logic              mem_signed;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              stall_req;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [BYTE_W-1:0] ram_dout;
  logic [BYTE_W-1:0] ram_din;

  modport master (
    output if_request, if_addr, mem_request, mem_addr, mem_wdata, mem_width, mem_signed, ram_din,
    input  mem_ctrl_data, if_or_mem_o, mem_rdata, mem_done, stall_req, ram_addr, ram_wr, ram_dout
  );

  modport slave (
    input  if_request, if_addr, mem_request, mem_addr, mem_wdata, mem_width, mem_signed, ram_din,
    output mem_ctrl_data, if_or_mem_o, mem_rdata, mem_done, stall_req, ram_addr, ram_wr, ram_dout
  );

endinterface

// File: rtl/mem_ctrl_ext.sv
// Load-result extension for byte/half loads. Sign extension exists only when
// MEM_CTRL_SIGN_EXT_EN is defined; otherwise narrow loads always zero-extend.
module mem_ctrl_ext
  import mem_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        width,
  input  logic              sgn,
  output logic [DATA_W-1:0] result_c
);

  logic fill_b_c;
  logic fill_h_c;

`ifdef MEM_CTRL_SIGN_EXT_EN
  assign fill_b_c = sgn & data[7];
  assign fill_h_c = sgn & data[15];
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign fill_b_c   = 1'b0;
  assign fill_h_c   = 1'b0;
`endif

  always_comb begin
    result_c = data;
    case (width)
      WIDTH_BYTE: result_c = {{(DATA_W-8){fill_b_c}}, data[7:0]};
      WIDTH_HALF: result_c = {{(DATA_W-16){fill_h_c}}, data[15:0]};
      default:    result_c = data;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM arbiter between instruction fetch and load/store, with a replay
// cycle that restores the fetch address. Load extension depends on MEM_CTRL_SIGN_EXT_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input logic     clk,
  input logic     rst,
  mem_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  mem_txn_t          txn_q, txn_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  last_q, last_d;
  logic [ADDR_W-1:0] saved_if_addr_q, saved_if_addr_d;
  logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              done_q, done_d;
  logic              stall_q, stall_d;

  logic [DATA_W-1:0] rd_merged_c;
  logic [DATA_W-1:0] rd_ext_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic              ram_wr_c;
  logic [BYTE_W-1:0] ram_dout_c;
  logic [1:0]        owner_c;

  // Partially assembled load with the byte arriving this cycle dropped into its lane.
  always_comb begin
    rd_merged_c = rd_buf_q;
    rd_merged_c[{cnt_q, 3'b000} +: BYTE_W] = bus.ram_din;
  end

  mem_ctrl_ext u_ext (
    .data     (rd_merged_c),
    .width    (txn_q.width),
    .sgn      (txn_q.sgn),
    .result_c (rd_ext_c)
  );

  // Next-state and RAM-port decode. The RAM returns data one cycle after the address,
  // so loads run the address one byte ahead of the capture lane.
  always_comb begin
    state_d         = state_q;
    txn_d           = txn_q;
    cnt_d           = cnt_q;
    last_d          = last_q;
    saved_if_addr_d = saved_if_addr_q;
    rd_buf_d        = rd_buf_q;
    mem_rdata_d     = mem_rdata_q;
    done_d          = 1'b0;
    stall_d         = stall_q;
    ram_addr_c      = bus.if_addr;
    ram_wr_c        = 1'b0;
    ram_dout_c      = '0;
    owner_c         = OWN_NONE;

    case (state_q)
      ST_IDLE: begin
        if (bus.if_request) owner_c = OWN_IF;
        if (bus.mem_request != REQ_NONE) begin
          txn_d.addr      = bus.mem_addr;
          txn_d.wdata     = bus.mem_wdata;
          txn_d.width     = bus.mem_width;
          txn_d.sgn       = bus.mem_signed;
          cnt_d           = '0;
          last_d          = last_byte_idx(bus.mem_width);
          saved_if_addr_d = bus.if_addr;
          stall_d         = 1'b1;
          if (bus.mem_request == REQ_STORE) begin
            state_d = ST_MEM_WR;
          end else begin
            state_d    = ST_MEM_RD;
            ram_addr_c = bus.mem_addr;
          end
        end
      end

      ST_MEM_RD: begin
        owner_c    = OWN_MEM;
        ram_addr_c = txn_q.addr + ADDR_W'(cnt_q) + ADDR_W'(1);
        rd_buf_d   = rd_merged_c;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == last_q) begin
          state_d     = ST_REPLAY;
          done_d      = 1'b1;
          mem_rdata_d = rd_ext_c;
        end
      end

      ST_MEM_WR: begin
        owner_c    = OWN_MEM;
        ram_addr_c = txn_q.addr + ADDR_W'(cnt_q);
        ram_wr_c   = 1'b1;
        ram_dout_c = txn_q.wdata[{cnt_q, 3'b000} +: BYTE_W];
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == last_q) begin
          state_d = ST_REPLAY;
          done_d  = 1'b1;
        end
      end

      ST_REPLAY: begin
        ram_addr_c = saved_if_addr_q;
        state_d    = ST_IDLE;
        stall_d    = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase

    // Reset must kill any in-flight write and hand the address back to IF immediately.
    if (rst) begin
      ram_addr_c = bus.if_addr;
      ram_wr_c   = 1'b0;
      owner_c    = OWN_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      txn_q           <= '0;
      cnt_q           <= '0;
      last_q          <= '0;
      saved_if_addr_q <= '0;
      rd_buf_q        <= '0;
      mem_rdata_q     <= '0;
      done_q          <= 1'b0;
      stall_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      txn_q           <= txn_d;
      cnt_q           <= cnt_d;
      last_q          <= last_d;
      saved_if_addr_q <= saved_if_addr_d;
      rd_buf_q        <= rd_buf_d;
      mem_rdata_q     <= mem_rdata_d;
      done_q          <= done_d;
      stall_q         <= stall_d;
    end
  end

  assign bus.mem_ctrl_data = bus.ram_din;
  assign bus.if_or_mem_o   = owner_c;
  assign bus.mem_rdata     = mem_rdata_q;
  assign bus.mem_done      = done_q;
  assign bus.stall_req     = stall_q;
  assign bus.ram_addr      = ram_addr_c;
  assign bus.ram_wr        = ram_wr_c;
  assign bus.ram_dout      = ram_dout_c;

endmodule
